matrix_row_feeder: RTL and testbench
====================================

MATRIX_ROW_FEEDER -- requirements
Module: matrix_row_feeder

Interface
REQ-001 SHALL have parameter element_width, default 32, meaning bits per matrix element.
REQ-002 SHALL have parameter no_of_row_by_vector_modules (M), default 4, meaning number of parallel row lanes fed.
REQ-003 SHALL have parameter NI, default 8, meaning elements per lane chunk.
REQ-004 SHALL have parameter ADDR_W, default 16, meaning chunk-memory address width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, meaning sole clock; all logic on rising edge.
REQ-007 Port reset, input, 1, meaning synchronous active-high reset.
REQ-008 Port start, input, 1, meaning operation enable; low aborts and clears the operation.
REQ-009 Port memories_pre_preprocess, input, 1, meaning one-cycle request for the next chunk set.
REQ-010 Port total_with_additional_A, input, 32, meaning matrix row count including padding rows.
REQ-011 Port row_length, input, 32, meaning elements per row; always a multiple of NI.
REQ-012 Port mem_rd_en, output, 1, meaning chunk-memory read strobe.
REQ-013 Port mem_addr, output, ADDR_W, meaning chunk address.
REQ-014 Port mem_rd_data, input, NI*element_width, meaning chunk data, valid one cycle after mem_rd_en.
REQ-015 Port A_rows, output, M*NI*element_width, meaning packed lane chunks; lane 0 in the MSB slice.
REQ-016 Port you_can_read, output, M, meaning per-lane data-valid pulse; lane 0 is the MSB.
REQ-017 Port no_of_multiples, output, M*32, meaning chunks per row for each lane; lane 0 in the MSB slice.
REQ-018 Port feeder_done, output, 1, meaning all rows delivered.

Function
REQ-019 SHALL implement FSM states IDLE, READ, LAST, PRESENT and DONE.
REQ-020 IDLE SHALL move to READ when start and memories_pre_preprocess are both high and not all groups are delivered.
REQ-021 READ SHALL last exactly M cycles, asserting mem_rd_en with lane counter L = 0..M-1.
REQ-022 mem_addr SHALL equal (group*M + L)*mult + chunk, where mult = row_length/NI, truncated to ADDR_W bits.
REQ-023 mem_rd_data SHALL be captured into lane L's A_rows slice one cycle after that lane's read, finishing in LAST.
REQ-024 PRESENT SHALL pulse you_can_read all-ones for exactly one cycle, then return to IDLE.
REQ-025 Latency SHALL be fixed: request at cycle t gives reads at t+1..t+M and you_can_read at t+M+2.
REQ-026 A_rows SHALL hold its value between updates.
REQ-027 After PRESENT, chunk SHALL increment; on chunk == mult-1, chunk SHALL wrap to 0 and group SHALL increment.
REQ-028 When group reaches ceil(total_with_additional_A/M), the FSM SHALL enter DONE and feeder_done SHALL be held high.
REQ-029 no_of_multiples SHALL be mult on every active lane, registered when a request is accepted.
REQ-030 A memory_pre_preprocess request arriving outside IDLE SHALL be ignored, with no queuing.
REQ-031 start low in any state SHALL, on the next edge, return the FSM to IDLE and clear group, chunk, feeder_done and you_can_read.
REQ-032 If row_length < NI (mult = 0), the FSM SHALL go straight to DONE without issuing reads.

Reset
REQ-033 On reset, state SHALL be IDLE, all counters 0, and A_rows, no_of_multiples, you_can_read, mem_rd_en, mem_addr and feeder_done all 0.
REQ-034 Reset mid-READ SHALL discard the partial group; an in-flight mem_rd_data SHALL not be captured.

Configuration
REQ-035 Macro FEEDER_ZERO_PAD_EN defined: lanes with row index >= total_with_additional_A SHALL issue no read, get zero A_rows data and no_of_multiples 0, and SHALL still receive the you_can_read pulse.
REQ-036 FEEDER_ZERO_PAD_EN undefined: every lane SHALL be read unconditionally; total_with_additional_A is a multiple of M.

Structure
REQ-037 Package matrix_feeder_pkg SHALL hold the FSM state enum, the zero-fill constant and default parameter values.
REQ-038 Address arithmetic SHALL live in sub-module row_chunk_addr_gen (inputs group, lane, chunk, mult; output mem_addr).

Verification
REQ-039 Setup M=4, NI=8, row_length=16, total=8: 4 requests SHALL give addresses {0,2,4,6},{1,3,5,7},{8,10,12,14},{9,11,13,15}, then feeder_done=1.
REQ-040 Single request at cycle 10: mem_rd_en high cycles 11-14; you_can_read=4'b1111 only at cycle 16.
REQ-041 Request repeated at cycle 12 during READ: ignored; exactly one you_can_read pulse.
REQ-042 start dropped at cycle 13 (mid-READ): cycle 14 IDLE with counters 0; next request restarts at address 0.
REQ-043 FEEDER_ZERO_PAD_EN, total=6, row_length=16: second group lanes 2-3 get A_rows=0 and no_of_multiples=0, with no reads issued for them.
REQ-044 reset asserted in PRESENT: next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/matrix_feeder_pkg.sv
// Shared types and defaults for the matrix row feeder: FSM state encoding,
// zero-fill value for padded lanes and default parameter values.
package matrix_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        LAST    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } feeder_state_e;

    localparam logic        ZERO_FILL_BIT     = 1'b0;
    localparam int unsigned DEF_ELEMENT_WIDTH = 32;
    localparam int unsigned DEF_NO_OF_LANES   = 4;
    localparam int unsigned DEF_NI            = 8;
    localparam int unsigned DEF_ADDR_W        = 16;

endpackage

// File: rtl/row_chunk_addr_gen.sv
// Chunk-memory address for one lane: (group*M + lane)*mult + chunk, truncated
// to ADDR_W bits.
module row_chunk_addr_gen
    import matrix_feeder_pkg::*;
#(
    parameter int unsigned M      = DEF_NO_OF_LANES,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LANE_W = 2
) (
    input  logic [31:0]       group,
    input  logic [LANE_W-1:0] lane,
    input  logic [31:0]       chunk,
    input  logic [31:0]       mult,
    output logic [ADDR_W-1:0] mem_addr
);

    logic [31:0] row_c;
    logic [31:0] full_c;

    always_comb begin
        row_c    = group * 32'(M) + 32'(lane);
        full_c   = row_c * mult + chunk;
        mem_addr = ADDR_W'(full_c);
    end

endmodule

// File: rtl/matrix_row_feeder.sv
// Feeds M row lanes with NI-element chunks read from a chunk memory, one lane
// read per cycle, then pulses you_can_read. Optional FEEDER_ZERO_PAD_EN
// zero-fills lanes whose row index lies beyond total_with_additional_A.
module matrix_row_feeder
    import matrix_feeder_pkg::*;
#(
    parameter int unsigned element_width               = DEF_ELEMENT_WIDTH,
    parameter int unsigned no_of_row_by_vector_modules = DEF_NO_OF_LANES,
    parameter int unsigned NI                          = DEF_NI,
    parameter int unsigned ADDR_W                      = DEF_ADDR_W
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 start,
    input  logic                                                 memories_pre_preprocess,
    input  logic [31:0]                                          total_with_additional_A,
    input  logic [31:0]                                          row_length,
    output logic                                                 mem_rd_en,
    output logic [ADDR_W-1:0]                                    mem_addr,
    input  logic [NI*element_width-1:0]                          mem_rd_data,
    output logic [no_of_row_by_vector_modules*NI*element_width-1:0] A_rows,
    output logic [no_of_row_by_vector_modules-1:0]               you_can_read,
    output logic [no_of_row_by_vector_modules*32-1:0]            no_of_multiples,
    output logic                                                 feeder_done
);

    localparam int unsigned M      = no_of_row_by_vector_modules;
    localparam int unsigned CW     = NI * element_width;
    localparam int unsigned LANE_W = (M > 1) ? $clog2(M) : 1;

    feeder_state_e     state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       group_q, group_d;
    logic [31:0]       chunk_q, chunk_d;
    logic [31:0]       mult_q, mult_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [M-1:0]      ycr_q, ycr_d;
    logic              done_q, done_d;
    logic [M*32-1:0]   nom_q, nom_d;
    logic [M*CW-1:0]   a_rows_q, a_rows_d;
    logic              cap_en_q, cap_en_d;
    logic              cap_zero_q, cap_zero_d;
    logic [LANE_W-1:0] cap_lane_q, cap_lane_d;

    logic [31:0]       mult_c;
    logic [32:0]       groups_c;
    logic              all_done_c;
    logic              last_group_c;
    logic [LANE_W-1:0] gen_lane_c;
    logic [ADDR_W-1:0] gen_addr_c;
    logic              gen_active_c;
    logic [M*32-1:0]   nom_accept_c;

    always_comb begin
        mult_c       = row_length / 32'(NI);
        groups_c     = ({1'b0, total_with_additional_A} + 33'(M - 1)) / 33'(M);
        all_done_c   = {1'b0, group_q} >= groups_c;
        last_group_c = ({1'b0, group_q} + 33'd1) >= groups_c;
        gen_lane_c   = (state_q == READ) ? lane_q + LANE_W'(1) : '0;
    end

    row_chunk_addr_gen #(
        .M      (M),
        .ADDR_W (ADDR_W),
        .LANE_W (LANE_W)
    ) u_addr_gen (
        .group    (group_q),
        .lane     (gen_lane_c),
        .chunk    (chunk_q),
        .mult     (mult_c),
        .mem_addr (gen_addr_c)
    );

`ifdef FEEDER_ZERO_PAD_EN
    logic [31:0] gen_row_c;

    always_comb begin
        gen_row_c    = group_q * 32'(M) + 32'(gen_lane_c);
        gen_active_c = gen_row_c < total_with_additional_A;
    end

    // Padding rows report zero chunks per row
    always_comb begin
        nom_accept_c = '0;
        for (int unsigned l = 0; l < M; l++) begin
            if (group_q * 32'(M) + 32'(l) < total_with_additional_A)
                nom_accept_c[(M-1-l)*32 +: 32] = mult_c;
        end
    end
`else
    assign gen_active_c = 1'b1;

    always_comb begin
        nom_accept_c = '0;
        for (int unsigned l = 0; l < M; l++) begin
            nom_accept_c[(M-1-l)*32 +: 32] = mult_c;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        group_d    = group_q;
        chunk_d    = chunk_q;
        mult_d     = mult_q;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        ycr_d      = '0;
        done_d     = done_q;
        nom_d      = nom_q;
        cap_en_d   = 1'b0;
        cap_zero_d = 1'b0;
        cap_lane_d = lane_q;
        a_rows_d   = a_rows_q;

        if (!start) begin
            state_d = IDLE;
            lane_d  = '0;
            group_d = '0;
            chunk_d = '0;
            done_d  = 1'b0;
        end else begin
            // Land the chunk requested last cycle into its lane slice
            for (int unsigned l = 0; l < M; l++) begin
                if (cap_en_q && cap_lane_q == LANE_W'(l))
                    a_rows_d[(M-1-l)*CW +: CW] = cap_zero_q ? {CW{ZERO_FILL_BIT}} : mem_rd_data;
            end

            unique case (state_q)
                IDLE: begin
                    if (mult_c == 32'd0 || all_done_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (memories_pre_preprocess) begin
                        state_d = READ;
                        lane_d  = '0;
                        mult_d  = mult_c;
                        nom_d   = nom_accept_c;
                        rd_en_d = gen_active_c;
                        addr_d  = gen_addr_c;
                    end
                end
                READ: begin
                    cap_en_d   = 1'b1;
                    cap_zero_d = !rd_en_q;
                    cap_lane_d = lane_q;
                    if (lane_q == LANE_W'(M - 1)) begin
                        state_d = LAST;
                    end else begin
                        lane_d  = gen_lane_c;
                        rd_en_d = gen_active_c;
                        addr_d  = gen_addr_c;
                    end
                end
                LAST: begin
                    state_d = PRESENT;
                    ycr_d   = '1;
                end
                PRESENT: begin
                    state_d = IDLE;
                    if (chunk_q == mult_q - 32'd1) begin
                        chunk_d = '0;
                        group_d = group_q + 32'd1;
                        if (last_group_c) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        chunk_d = chunk_q + 32'd1;
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            group_q    <= '0;
            chunk_q    <= '0;
            mult_q     <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            ycr_q      <= '0;
            done_q     <= 1'b0;
            nom_q      <= '0;
            a_rows_q   <= '0;
            cap_en_q   <= 1'b0;
            cap_zero_q <= 1'b0;
            cap_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            group_q    <= group_d;
            chunk_q    <= chunk_d;
            mult_q     <= mult_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            ycr_q      <= ycr_d;
            done_q     <= done_d;
            nom_q      <= nom_d;
            a_rows_q   <= a_rows_d;
            cap_en_q   <= cap_en_d;
            cap_zero_q <= cap_zero_d;
            cap_lane_q <= cap_lane_d;
        end
    end

    assign mem_rd_en       = rd_en_q;
    assign mem_addr        = addr_q;
    assign you_can_read    = ycr_q;
    assign feeder_done     = done_q;
    assign no_of_multiples = nom_q;
    assign A_rows          = a_rows_q;

endmodule

// File: tb/tb_matrix_row_feeder.sv
// Self-checking bench for matrix_row_feeder: configuration table, hand-written
// abort/reset sequences and randomized request streams against a request-level model.
module tb_matrix_row_feeder;

    localparam int EW     = 32;
    localparam int M      = 4;
    localparam int NI     = 8;
    localparam int ADDR_W = 16;
    localparam int CW     = NI * EW;
`ifdef FEEDER_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              req;
    logic [31:0]       total;
    logic [31:0]       row_length;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [CW-1:0]     mem_rd_data;
    logic [M*CW-1:0]   a_rows;
    logic [M-1:0]      ycr;
    logic [M*32-1:0]   nom;
    logic              feeder_done;

    int errors = 0;
    int checks = 0;

    int m_group, m_chunk, m_mult, m_total;
    logic [ADDR_W-1:0] addr_log[$];

    typedef struct {
        int row_length;
        int total;
        int n_req;
    } cfg_t;

    cfg_t              cfgs[6];
    logic [ADDR_W-1:0] exp_seq[16];
    int                rl, tot, gap;

    matrix_row_feeder #(
        .element_width               (EW),
        .no_of_row_by_vector_modules (M),
        .NI                          (NI),
        .ADDR_W                      (ADDR_W)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .memories_pre_preprocess (req),
        .total_with_additional_A (total),
        .row_length              (row_length),
        .mem_rd_en               (mem_rd_en),
        .mem_addr                (mem_addr),
        .mem_rd_data             (mem_rd_data),
        .A_rows                  (a_rows),
        .you_can_read            (ycr),
        .no_of_multiples         (nom),
        .feeder_done             (feeder_done)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [CW-1:0] r;
        for (int e = 0; e < NI; e++) r[e*EW +: EW] = {a, 8'(e), 8'h3C};
        return r;
    endfunction

    // Chunk memory: one-cycle read latency, junk whenever not strobed
    always @(posedge clk) mem_rd_data <= mem_rd_en ? pattern(mem_addr) : {NI{32'hBADF00D5}};

    function automatic bit lane_active(input int g, input int l);
        return !ZP || ((g * M + l) < m_total);
    endfunction

    function automatic bit m_done();
        return (m_mult == 0) || (m_group >= (m_total + M - 1) / M);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_lane(input string name, input int l, input logic [CW-1:0] exp);
        logic [CW-1:0] act;
        act = a_rows[(M-1-l)*CW +: CW];
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane %0d: got %0h expected %0h at %0t", name, l, act, exp, $time);
        end
    endtask

    task automatic restart(input int r_len, input int t_rows);
        start = 1'b0;
        req   = 1'b0;
        tick();
        chk("abort_done", 64'(feeder_done), 64'(0));
        chk("abort_ycr", 64'(ycr), 64'(0));
        row_length = 32'(r_len);
        total      = 32'(t_rows);
        start      = 1'b1;
        m_group    = 0;
        m_chunk    = 0;
        m_mult     = r_len / NI;
        m_total    = t_rows;
        addr_log.delete();
    endtask

    // One request issued now; checks every cycle up to the cycle after the pulse
    task automatic run_request(input bit dup);
        bit                act;
        logic [ADDR_W-1:0] ea;
        logic [CW-1:0]     exp_lane[M];
        int                exp_nom[M];
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int l = 0; l < M; l++) begin
            act         = lane_active(m_group, l);
            ea          = ADDR_W'((m_group * M + l) * m_mult + m_chunk);
            exp_lane[l] = act ? pattern(ea) : '0;
            exp_nom[l]  = act ? m_mult : 0;
            chk("rd_en", 64'(mem_rd_en), 64'(act));
            if (act) begin
                chk("addr", 64'(mem_addr), 64'(ea));
                addr_log.push_back(mem_addr);
            end
            chk("ycr_quiet", 64'(ycr), 64'(0));
            req = dup && (l == 1);
            tick();
        end
        req = 1'b0;
        chk("last_rd_en", 64'(mem_rd_en), 64'(0));
        chk("last_ycr", 64'(ycr), 64'(0));
        tick();
        chk("ycr_pulse", 64'(ycr), 64'({M{1'b1}}));
        for (int l = 0; l < M; l++) begin
            chk_lane("a_rows", l, exp_lane[l]);
            chk("no_of_multiples", 64'(nom[(M-1-l)*32 +: 32]), 64'(exp_nom[l]));
        end
        tick();
        chk("ycr_after", 64'(ycr), 64'(0));
        chk_lane("a_rows_hold", 0, exp_lane[0]);
        m_chunk++;
        if (m_chunk == m_mult) begin
            m_chunk = 0;
            m_group++;
        end
        chk("feeder_done", 64'(feeder_done), 64'(m_done()));
    endtask

    task automatic chk_lanes_zero(input string name);
        for (int l = 0; l < M; l++) chk_lane(name, l, '0);
    endtask

    initial begin
        cfgs[0] = '{row_length: 16, total: 8,  n_req: 4};
        cfgs[1] = '{row_length: 8,  total: 4,  n_req: 1};
        cfgs[2] = '{row_length: 24, total: 4,  n_req: 3};
        cfgs[3] = '{row_length: 32, total: 12, n_req: 12};
        cfgs[4] = '{row_length: 4,  total: 8,  n_req: 0};
        cfgs[5] = '{row_length: 0,  total: 4,  n_req: 0};
        exp_seq = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};

        reset = 1'b1;
        start = 1'b0;
        req = 1'b0;
        total = '0;
        row_length = '0;
        repeat (3) tick();
        chk("rst_rd_en", 64'(mem_rd_en), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_ycr", 64'(ycr), 64'(0));
        chk("rst_done", 64'(feeder_done), 64'(0));
        chk("rst_nom", 64'(nom), 64'(0));
        chk_lanes_zero("rst_a_rows");
        reset = 1'b0;
        tick();

        // Configuration table
        for (int i = 0; i < 6; i++) begin
            restart(cfgs[i].row_length, cfgs[i].total);
            if (cfgs[i].n_req == 0) begin
                req = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    req = 1'b0;
                    chk("mult0_rd_en", 64'(mem_rd_en), 64'(0));
                end
            end else begin
                for (int k = 0; k < cfgs[i].n_req; k++) run_request(1'b0);
            end
            if (i == 0) begin
                chk("seq_count", 64'(addr_log.size()), 64'(16));
                for (int k = 0; k < 16 && k < addr_log.size(); k++)
                    chk("seq_addr", 64'(addr_log[k]), 64'(exp_seq[k]));
            end
            chk("cfg_done", 64'(feeder_done), 64'(1));
            req = 1'b1;
            tick();
            req = 1'b0;
            for (int k = 0; k < M + 2; k++) begin
                chk("done_rd_en", 64'(mem_rd_en), 64'(0));
                chk("done_ycr", 64'(ycr), 64'(0));
                tick();
            end
            chk("done_hold", 64'(feeder_done), 64'(1));
        end

        // Duplicate request during READ is dropped, not queued
        restart(16, 8);
        run_request(1'b1);
        for (int k = 0; k < M + 3; k++) begin
            chk("dup_rd_en", 64'(mem_rd_en), 64'(0));
            chk("dup_ycr", 64'(ycr), 64'(0));
            tick();
        end

        // start dropped mid-READ
        restart(16, 8);
        run_request(1'b0);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        start = 1'b0;
        tick();
        chk("abort_rd_en", 64'(mem_rd_en), 64'(0));
        chk("abort_ycr_mid", 64'(ycr), 64'(0));
        chk("abort_done_mid", 64'(feeder_done), 64'(0));
        start = 1'b1;
        m_group = 0;
        m_chunk = 0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_pulse", 64'(ycr), 64'(0));
            tick();
        end
        run_request(1'b0);

        // Reset asserted in PRESENT
        restart(16, 8);
        run_request(1'b0);
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (M + 1) tick();
        chk("pres_ycr", 64'(ycr), 64'({M{1'b1}}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("prst_rd_en", 64'(mem_rd_en), 64'(0));
        chk("prst_addr", 64'(mem_addr), 64'(0));
        chk("prst_ycr", 64'(ycr), 64'(0));
        chk("prst_nom", 64'(nom), 64'(0));
        chk("prst_done", 64'(feeder_done), 64'(0));
        chk_lanes_zero("prst_a_rows");
        m_group = 0;
        m_chunk = 0;
        run_request(1'b0);

        // Reset mid-READ: in-flight chunk must not land
        restart(16, 8);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_lanes_zero("rrst_a_rows");
            chk("rrst_ycr", 64'(ycr), 64'(0));
            chk("rrst_rd_en", 64'(mem_rd_en), 64'(0));
            tick();
        end

`ifdef FEEDER_ZERO_PAD_EN
        // Padding rows in the second group
        restart(16, 6);
        for (int k = 0; k < 4; k++) run_request(1'b0);
        chk("zp_done", 64'(feeder_done), 64'(1));
`endif

        // Randomized streams
        for (int it = 0; it < 6; it++) begin
            rl = NI * int'($urandom_range(1, 3));
            tot = ZP ? int'($urandom_range(1, 12)) : M * int'($urandom_range(1, 3));
            restart(rl, tot);
            while (!m_done()) begin
                gap = int'($urandom_range(0, 2));
                for (int k = 0; k < gap; k++) begin
                    chk("gap_rd_en", 64'(mem_rd_en), 64'(0));
                    tick();
                end
                run_request(1'($urandom_range(0, 1)));
            end
            chk("rand_done", 64'(feeder_done), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
